// File: rtl/grid_move_ctrl.sv
// Tile-by-tile player motion for the 20x15 VGA maze: accepts one-hot direction
// requests, checks the target tile against the walkability map and slides the sprite.
module grid_move_ctrl #(
    parameter int MAP_W     = 20,
    parameter int MAP_H     = 15,
    parameter int TILE      = 32,
    parameter int STEP_PX   = 4,
    parameter int H_ORIGIN  = 144,
    parameter int V_ORIGIN  = 31,
    parameter int START_COL = 0,
    parameter int START_ROW = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   move_tick,
    input  logic [3:0]             dir,
    input  logic                   freeze,
    input  logic [MAP_W*MAP_H-1:0] wall_map,
    output logic [9:0]             hpos,
    output logic [9:0]             vpos,
    output logic [4:0]             tile_col,
    output logic [3:0]             tile_row,
    output logic [3:0]             facing,
    output logic [1:0]             anim_step,
    output logic                   moving,
    output logic                   bump
);

    localparam int IDX_W = $clog2(MAP_W * MAP_H);
    localparam int SUB_W = $clog2(TILE) + 2;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] MOVE  = 2'd2;

    localparam logic [3:0] DIR_UP    = 4'b1000;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_RIGHT = 4'b0001;

    localparam logic signed [SUB_W-1:0] STEP_S = SUB_W'(STEP_PX);
    localparam logic signed [SUB_W-1:0] TILE_S = SUB_W'(TILE);

    logic [1:0]              state;
    logic [3:0]              move_dir;
    logic [4:0]              tgt_col;
    logic [3:0]              tgt_row;
    logic                    tgt_oob;
    logic signed [SUB_W-1:0] hsub;
    logic signed [SUB_W-1:0] vsub;

    logic                    dir_onehot;
    logic [4:0]              nxt_col;
    logic [3:0]              nxt_row;
    logic                    nxt_oob;
    logic [IDX_W-1:0]        map_idx;
    logic                    tgt_blocked;
    logic signed [SUB_W-1:0] hsub_nxt;
    logic signed [SUB_W-1:0] vsub_nxt;
    logic                    arrive;
    logic [9:0]              hsub_ext;
    logic [9:0]              vsub_ext;
    logic [9:0]              col_px;
    logic [9:0]              row_px;

    assign dir_onehot = (dir != 4'b0000) && ((dir & (dir - 4'd1)) == 4'b0000);

    // Edge tiles are flagged out of bounds here so the map is never indexed with a wrapped target.
    always_comb begin
        nxt_col = tile_col;
        nxt_row = tile_row;
        nxt_oob = 1'b0;
        case (dir)
            DIR_UP: begin
                if (tile_row == 4'd0) nxt_oob = 1'b1;
                else                  nxt_row = tile_row - 4'd1;
            end
            DIR_DOWN: begin
                if (tile_row == 4'(MAP_H - 1)) nxt_oob = 1'b1;
                else                           nxt_row = tile_row + 4'd1;
            end
            DIR_LEFT: begin
                if (tile_col == 5'd0) nxt_oob = 1'b1;
                else                  nxt_col = tile_col - 5'd1;
            end
            DIR_RIGHT: begin
                if (tile_col == 5'(MAP_W - 1)) nxt_oob = 1'b1;
                else                           nxt_col = tile_col + 5'd1;
            end
            default: ;
        endcase
    end

    assign map_idx     = IDX_W'(tgt_row) * IDX_W'(MAP_W) + IDX_W'(tgt_col);
    assign tgt_blocked = tgt_oob || !wall_map[map_idx];

    always_comb begin
        hsub_nxt = hsub;
        vsub_nxt = vsub;
        case (move_dir)
            DIR_RIGHT: hsub_nxt = hsub + STEP_S;
            DIR_LEFT:  hsub_nxt = hsub - STEP_S;
            DIR_DOWN:  vsub_nxt = vsub + STEP_S;
            DIR_UP:    vsub_nxt = vsub - STEP_S;
            default: ;
        endcase
    end

    assign arrive = (hsub_nxt == TILE_S) || (hsub_nxt == -TILE_S) ||
                    (vsub_nxt == TILE_S) || (vsub_nxt == -TILE_S);

    assign hsub_ext = {{(10 - SUB_W){hsub[SUB_W-1]}}, hsub};
    assign vsub_ext = {{(10 - SUB_W){vsub[SUB_W-1]}}, vsub};
    assign col_px   = 10'(tile_col) * 10'(TILE);
    assign row_px   = 10'(tile_row) * 10'(TILE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tile_col  <= 5'(START_COL);
            tile_row  <= 4'(START_ROW);
            tgt_col   <= 5'(START_COL);
            tgt_row   <= 4'(START_ROW);
            tgt_oob   <= 1'b0;
            move_dir  <= DIR_DOWN;
            hsub      <= '0;
            vsub      <= '0;
            hpos      <= 10'(H_ORIGIN + START_COL * TILE);
            vpos      <= 10'(V_ORIGIN + START_ROW * TILE);
            facing    <= DIR_DOWN;
            anim_step <= 2'd0;
            moving    <= 1'b0;
            bump      <= 1'b0;
        end else begin
            bump <= 1'b0;
            hpos <= 10'(H_ORIGIN) + col_px + hsub_ext;
            vpos <= 10'(V_ORIGIN) + row_px + vsub_ext;
            case (state)
                IDLE: begin
                    if (move_tick && !freeze && dir_onehot) begin
                        facing   <= dir;
                        move_dir <= dir;
                        tgt_col  <= nxt_col;
                        tgt_row  <= nxt_row;
                        tgt_oob  <= nxt_oob;
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    if (tgt_blocked) begin
                        bump  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        moving <= 1'b1;
                        state  <= MOVE;
                    end
                end
                MOVE: begin
                    // Commit on the arriving tick so the position never shows tile+TILE.
                    if (move_tick && !freeze) begin
                        if (arrive) begin
                            tile_col  <= tgt_col;
                            tile_row  <= tgt_row;
                            hsub      <= '0;
                            vsub      <= '0;
                            moving    <= 1'b0;
                            anim_step <= 2'd0;
                            state     <= IDLE;
                        end else begin
                            hsub      <= hsub_nxt;
                            vsub      <= vsub_nxt;
                            anim_step <= anim_step + 2'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
